// File: rtl/rasterizer_pkg.sv
// rtl/rasterizer_pkg.sv - shared types, widths and arithmetic helpers for the rasterizer
// Contents: FSM state enum, 9-bit coordinate and vertex types, signed
// delta/edge types, edge-function and bounding-box helpers.
package rasterizer_pkg;

  localparam int COORD_W = 9;
  localparam int DELTA_W = COORD_W + 1;
  // |delta| <= 511, so each product fits in 19 bits and the difference in 21;
  // one spare bit keeps the sign unambiguous.
  localparam int EDGE_W  = 22;

  typedef logic [COORD_W-1:0] coord_t;
  typedef coord_t vertex_t [2:0];  // [2]=x, [1]=y, [0]=z (z ignored)
  typedef logic signed [DELTA_W-1:0] delta_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SETUP, ST_RASTER} state_t;

  function automatic delta_t diff(input coord_t a, input coord_t b);
    return delta_t'({1'b0, a}) - delta_t'({1'b0, b});
  endfunction

  // E = px*dy - py*dx, where (px,py) is the point relative to the edge start
  function automatic edge_t edge_fn(input delta_t px, input delta_t py,
                                    input delta_t dy, input delta_t dx);
    return edge_t'(px) * edge_t'(dy) - edge_t'(py) * edge_t'(dx);
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/raster_framebuffer.sv
// rtl/raster_framebuffer.sv - two 1-bit coverage banks, shared write port, registered read port
// Ports: clk_in; wr_en[1:0] per-bank write enable (both set = write both banks);
// wr_addr/wr_data write port; rd_bank/rd_addr read select; rd_data registered bit.
module raster_framebuffer #(
  parameter int DEPTH  = 129600,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic [1:0]        wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic mem0 [DEPTH];
  logic mem1 [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en[0]) mem0[wr_addr] <= wr_data;
    if (wr_en[1]) mem1[wr_addr] <= wr_data;
    rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

endmodule

// File: rtl/rasterizer.sv
// rtl/rasterizer.sv - double-buffered 1-bit triangle rasterizer with display readout
// Ports: clk_in, rst_in (async, active-low); vert1..3 triangle vertices;
// valid_tri/obj_done/new_frame strobes; hcount/vcount display position;
// color_out display pixel (2-cycle latency); ready_out high in IDLE.
module rasterizer
  import rasterizer_pkg::*;
#(
  parameter int WIDTH  = 360,
  parameter int HEIGHT = 360
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  vertex_t     vert1,
  input  vertex_t     vert2,
  input  vertex_t     vert3,
  input  logic        valid_tri,
  input  logic        obj_done,
  input  logic        new_frame,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  color_out,
  output logic        ready_out
);

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam coord_t X_MAX = coord_t'(WIDTH - 1);
  localparam coord_t Y_MAX = coord_t'(HEIGHT - 1);

  state_t state, state_nxt;
  logic   draw_bank, done_pending, nf_pending, clear_both;
  logic   swap, accept;
  logic [ADDR_W-1:0] clr_addr, pix_addr, rd_addr;
  coord_t xa, ya, xb, yb, xc, yc;
  coord_t min_x, max_x, min_y, max_y, cur_x, cur_y;
  delta_t dx_ab, dy_ab, dx_bc, dy_bc, dx_ca, dy_ca;
  logic   degen;
  edge_t  e_ab, e_bc, e_ca;
  logic   col_end, row_end, covered, clr_we, in_range, in_range_q, rd_data;
  logic [1:0] wr_en;
  logic   unused_z;

  assign unused_z = ^{vert1[0], vert2[0], vert3[0]};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_CLEAR;
    else         state <= state_nxt;
  end

  assign col_end = (cur_x == max_x);
  assign row_end = (cur_y == max_y);

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    swap      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
      ST_IDLE: begin
        ready_out = 1'b1;
        // A frame swap wins over a simultaneous triangle, which is dropped.
        if ((new_frame || nf_pending) && (done_pending || obj_done)) begin
          swap      = 1'b1;
          state_nxt = ST_CLEAR;
        end else if (valid_tri) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  state_nxt = ST_RASTER;
      ST_RASTER: if (col_end && row_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_CLEAR;
    endcase
  end

  // Frame bookkeeping and the clear sweep.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      draw_bank    <= 1'b0;
      done_pending <= 1'b0;
      nf_pending   <= 1'b0;
      clear_both   <= 1'b1;
      clr_addr     <= '0;
    end else begin
      if (swap) begin
        draw_bank    <= ~draw_bank;
        done_pending <= 1'b0;
      end else if (obj_done) begin
        done_pending <= 1'b1;
      end
      if (state == ST_IDLE) nf_pending <= 1'b0;
      else if (new_frame)   nf_pending <= 1'b1;
      if (state == ST_CLEAR) begin
        if (clr_addr == LAST_ADDR) begin
          clr_addr   <= '0;
          clear_both <= 1'b0;
        end else begin
          clr_addr <= clr_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Triangle datapath: latch, setup, scan.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      xa <= vert1[2]; ya <= vert1[1];
      xb <= vert2[2]; yb <= vert2[1];
      xc <= vert3[2]; yc <= vert3[1];
    end
    if (state == ST_SETUP) begin
      dx_ab <= diff(xb, xa); dy_ab <= diff(yb, ya);
      dx_bc <= diff(xc, xb); dy_bc <= diff(yc, yb);
      dx_ca <= diff(xa, xc); dy_ca <= diff(ya, yc);
      // Zero signed area means every edge function is zero on the shared line.
      degen <= (edge_fn(diff(xc, xa), diff(yc, ya), diff(yb, ya), diff(xb, xa)) == '0);
      min_x <= (min3(xa, xb, xc) > X_MAX) ? X_MAX : min3(xa, xb, xc);
      max_x <= (max3(xa, xb, xc) > X_MAX) ? X_MAX : max3(xa, xb, xc);
      min_y <= (min3(ya, yb, yc) > Y_MAX) ? Y_MAX : min3(ya, yb, yc);
      max_y <= (max3(ya, yb, yc) > Y_MAX) ? Y_MAX : max3(ya, yb, yc);
      cur_x <= (min3(xa, xb, xc) > X_MAX) ? X_MAX : min3(xa, xb, xc);
      cur_y <= (min3(ya, yb, yc) > Y_MAX) ? Y_MAX : min3(ya, yb, yc);
    end else if (state == ST_RASTER) begin
      if (col_end) begin
        cur_x <= min_x;
        cur_y <= cur_y + coord_t'(1);
      end else begin
        cur_x <= cur_x + coord_t'(1);
      end
    end
  end

  assign e_ab = edge_fn(diff(cur_x, xa), diff(cur_y, ya), dy_ab, dx_ab);
  assign e_bc = edge_fn(diff(cur_x, xb), diff(cur_y, yb), dy_bc, dx_bc);
  assign e_ca = edge_fn(diff(cur_x, xc), diff(cur_y, yc), dy_ca, dx_ca);

  assign covered = (state == ST_RASTER) && !degen &&
                   ((!e_ab[EDGE_W-1] && !e_bc[EDGE_W-1] && !e_ca[EDGE_W-1]) ||
                    ((e_ab[EDGE_W-1] || e_ab == '0) &&
                     (e_bc[EDGE_W-1] || e_bc == '0) &&
                     (e_ca[EDGE_W-1] || e_ca == '0)));

  assign clr_we   = (state == ST_CLEAR);
  assign pix_addr = ADDR_W'(int'(cur_y) * WIDTH + int'(cur_x));
  assign wr_en[0] = (clr_we && (clear_both || !draw_bank)) || (covered && !draw_bank);
  assign wr_en[1] = (clr_we && (clear_both ||  draw_bank)) || (covered &&  draw_bank);

  // Out-of-frame positions read address 0 and are masked one stage later.
  assign in_range = (int'(hcount) < WIDTH) && (int'(vcount) < HEIGHT);
  assign rd_addr  = in_range ? ADDR_W'(int'(vcount) * WIDTH + int'(hcount)) : '0;

  raster_framebuffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fb (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr (clr_we ? clr_addr : pix_addr),
    .wr_data (!clr_we),
    .rd_bank (~draw_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      in_range_q <= 1'b0;
      color_out  <= 8'h00;
    end else begin
      in_range_q <= in_range;
      color_out  <= (in_range_q && rd_data) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_rasterizer.sv
// tb/tb_rasterizer.sv - self-checking bench for the rasterizer
module tb_rasterizer;
  import rasterizer_pkg::*;

  localparam int W = 40;
  localparam int H = 32;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  vertex_t     v1, v2, v3;
  logic        valid_tri, obj_done, new_frame;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  color;
  logic        ready;

  int checks = 0;
  int passed = 0;
  int cnt;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] c;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  rasterizer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .vert1     (v1),
    .vert2     (v2),
    .vert3     (v3),
    .valid_tri (valid_tri),
    .obj_done  (obj_done),
    .new_frame (new_frame),
    .hcount    (hcount),
    .vcount    (vcount),
    .color_out (color),
    .ready_out (ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!ready && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
    v1[2] = coord_t'(ax); v1[1] = coord_t'(ay); v1[0] = '0;
    v2[2] = coord_t'(bx); v2[1] = coord_t'(by); v2[0] = '0;
    v3[2] = coord_t'(cx); v3[1] = coord_t'(cy); v3[0] = '0;
  endtask

  task automatic submit(input int ax, input int ay, input int bx, input int by,
                        input int cx, input int cy);
    set_tri(ax, ay, bx, by, cx, cy);
    valid_tri = 1'b1;
    obj_done  = 1'b1;
    tick();
    valid_tri = 1'b0;
    obj_done  = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  function automatic logic exp_px(input int id, input int x, input int y);
    case (id)
      1:       return (x >= 5) && (y >= 5) && (x + y <= 15);
      2:       return (x >= 30) && (y >= 22);
      default: return 1'b0;
    endcase
  endfunction

  task automatic sweep(input string name, input int id, input int exp_ones);
    int ones;
    int bad;
    ones = 0;
    bad  = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        hcount = 11'(x);
        vcount = 10'(y);
        tick();
        tick();
        if (color == 8'hFF) ones++;
        if (color != (exp_px(id, x, y) ? 8'hFF : 8'h00)) bad++;
      end
    end
    check({name, " lit pixels"}, ones, exp_ones);
    check({name, " wrong pixels"}, bad, 0);
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      hcount = 11'(tbl[i].h);
      vcount = 10'(tbl[i].v);
      tick();
      tick();
      check($sformatf("%s[%0d] (%0d,%0d)", tag, i, tbl[i].h, tbl[i].v),
            int'(color), int'(tbl[i].c));
    end
  endtask

  initial begin
    // Display expectations while the clamped-triangle frame is shown.
    tbl[0] = '{39, 31, 8'hFF};   // bottom-right corner of the frame
    tbl[1] = '{30, 22, 8'hFF};
    tbl[2] = '{29, 22, 8'h00};
    tbl[3] = '{30, 21, 8'h00};
    tbl[4] = '{0, 23, 8'h00};    // where an x=40 write would wrap to
    tbl[5] = '{9, 23, 8'h00};
    tbl[6] = '{70, 22, 8'h00};   // aliases (30,23) without range check
    tbl[7] = '{400, 22, 8'h00};
    tbl[8] = '{35, 40, 8'h00};
    tbl[9] = '{35, 25, 8'hFF};

    rst_n = 1'b0; valid_tri = 1'b0; obj_done = 1'b0; new_frame = 1'b0;
    hcount = '0; vcount = '0;
    set_tri(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", int'(ready), 0);
    check("reset color", int'(color), 0);
    rst_n = 1'b1;
    wait_ready(N + 100, cnt);
    check("init clear cycles", cnt, N);
    sweep("init", 0, 0);

    submit(5, 5, 10, 5, 5, 10);
    wait_ready(200, cnt);
    check("tri busy cycles", cnt, 37);
    pulse_nf();
    check("swap ready low", int'(ready), 0);
    wait_ready(N + 100, cnt);
    check("swap clear cycles", cnt, N);
    sweep("tri", 1, 21);

    submit(5, 10, 10, 5, 5, 5);
    wait_ready(200, cnt);
    check("reversed busy cycles", cnt, 37);
    pulse_nf();
    wait_ready(N + 100, cnt);
    check("reversed clear cycles", cnt, N);
    sweep("reversed", 1, 21);

    submit(30, 22, 80, 22, 30, 72);
    wait_ready(300, cnt);
    check("clamp busy cycles", cnt, 101);
    pulse_nf();
    wait_ready(N + 100, cnt);
    check("clamp clear cycles", cnt, N);
    sweep("clamp", 2, 100);
    apply_table("clamp");

    pulse_nf();
    check("no-done ready", int'(ready), 1);
    apply_table("no-swap");

    // Collinear triangle; a second triangle is held on valid_tri throughout
    // and a new_frame arrives mid-scan, so the swap is serviced on return
    // to IDLE and must win over the still-asserted valid_tri.
    submit(0, 0, 4, 4, 8, 8);
    set_tri(5, 5, 10, 5, 5, 10);
    valid_tri = 1'b1;
    repeat (10) tick();
    pulse_nf();
    wait_ready(300, cnt);
    check("collinear busy cycles", cnt + 11, 82);
    tick();
    check("pending swap ready low", int'(ready), 0);
    valid_tri = 1'b0;
    wait_ready(N + 100, cnt);
    check("pending clear cycles", cnt, N);
    sweep("collinear", 0, 0);

    // Reset in the middle of a scan, then show the aborted draw buffer.
    submit(0, 0, 39, 0, 0, 31);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check("mid reset ready", int'(ready), 0);
    check("mid reset color", int'(color), 0);
    rst_n = 1'b1;
    wait_ready(N + 100, cnt);
    check("re-clear cycles", cnt, N);
    obj_done = 1'b1;
    tick();
    obj_done = 1'b0;
    pulse_nf();
    wait_ready(N + 100, cnt);
    check("post-reset swap cycles", cnt, N);
    sweep("post-reset", 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
